// File: rtl/pmod_debounce.sv
// Synchronises and debounces raw PMOD inputs, one independent channel per bit.
// Each channel provides a clean level, registered rise/fall pulses and a press toggle.
module pmod_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pmod,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] toggle
);

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pmod;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : gen_chan
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             toggle_q, toggle_d;
    logic             s;
    logic             level_bit;

    assign s = sync2[g];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= StStableLo;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        toggle_q <= toggle_d;
      end
    end

    // The counter is cleared on every WAIT entry and only compared while waiting,
    // so it can never wrap.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      toggle_d = toggle_q;
      case (state_q)
        StStableLo: begin
          if (s) begin
            state_d = StWaitHi;
            cnt_d   = '0;
          end
        end
        StWaitHi: begin
          if (!s) begin
            state_d = StStableLo;
          end else if (cnt_q == CntLast) begin
            state_d  = StStableHi;
            rise_d   = 1'b1;
            toggle_d = ~toggle_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StStableHi: begin
          if (!s) begin
            state_d = StWaitLo;
            cnt_d   = '0;
          end
        end
        StWaitLo: begin
          if (s) begin
            state_d = StStableHi;
          end else if (cnt_q == CntLast) begin
            state_d = StStableLo;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StStableLo;
        end
      endcase
    end

    // While waiting to fall the accepted level is still high.
    always_comb begin
      level_bit = (state_q == StStableHi) || (state_q == StWaitLo);
    end

    assign level[g]  = level_bit;
    assign rise[g]   = rise_q;
    assign fall[g]   = fall_q;
    assign toggle[g] = toggle_q;
  end

endmodule

// File: tb/tb_pmod_debounce.sv
// Scoreboard bench for pmod_debounce with DEBOUNCE_CYCLES=8: stimulus queues the
// expected pulse events, a monitor pops and compares them as pulses appear.
module tb_pmod_debounce;

  localparam int unsigned D   = 8;
  localparam int          LAT = D + 3;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pmod    = 2'b00;
  logic [1:0] level, rise, fall, toggle;

  pmod_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pmod   (pmod),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .toggle (toggle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] level;
    logic [1:0] toggle;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [1:0] m_level  = 2'b00;
  logic [1:0] m_toggle = 2'b00;
  int         n_vec    = 0;
  int         n_err    = 0;

  task automatic push_ev(input int at, input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    m_level  = (m_level | r) & ~f;
    m_toggle = m_toggle ^ r;
    e.cyc    = at;
    e.rise   = r;
    e.fall   = f;
    e.level  = m_level;
    e.toggle = m_toggle;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the queue; overdue entries are misses.
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: expected rise=%b fall=%b at cycle %0d, none by cycle %0d",
                 exp_q[0].rise, exp_q[0].fall, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if ((rise | fall) != 2'b00) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got rise=%b fall=%b at cycle %0d, expected none",
                   rise, fall, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.rise !== rise || mon_e.fall !== fall ||
              mon_e.level !== level || mon_e.toggle !== toggle) begin
            n_err++;
            $display({"FAIL pulse_event: got cyc=%0d rise=%b fall=%b level=%b toggle=%b, ",
                      "expected cyc=%0d rise=%b fall=%b level=%b toggle=%b"},
                     cyc, rise, fall, level, toggle,
                     mon_e.cyc, mon_e.rise, mon_e.fall, mon_e.level, mon_e.toggle);
          end
        end
      end
    end
  end

  initial begin
    int widths[3] = '{3, 5, 8};

    // 1: reset and idle
    step(3);
    check("reset_outputs", {level, rise, fall, toggle}, 8'h00);
    reset_n = 1'b1;
    step(50);
    check("idle_outputs", {level, rise, fall, toggle}, 8'h00);

    // 2: enable switch goes high
    pmod[1] = 1'b1;
    push_ev(cyc + LAT, 2'b10, 2'b00);
    step(20);
    check("t2_level", {6'b0, level}, 8'h02);
    check("t2_toggle", {6'b0, toggle}, 8'h02);

    // 3: short pulses on channel 0 are all rejected, including the 8-cycle one
    foreach (widths[i]) begin
      pmod[0] = 1'b1;
      step(widths[i]);
      pmod[0] = 1'b0;
      step(12);
    end
    check("t3_level", {6'b0, level}, 8'h02);
    check("t3_toggle", {6'b0, toggle}, 8'h02);

    // 4: two clean presses on channel 0
    repeat (2) begin
      pmod[0] = 1'b1;
      push_ev(cyc + LAT, 2'b01, 2'b00);
      step(20);
      pmod[0] = 1'b0;
      push_ev(cyc + LAT, 2'b00, 2'b01);
      step(20);
    end
    check("t4_level", {6'b0, level}, 8'h02);
    check("t4_toggle", {6'b0, toggle}, 8'h02);

    // 5: reset while channel 1 is in WAIT_HI with cnt=4
    pmod[1] = 1'b0;
    push_ev(cyc + LAT, 2'b00, 2'b10);
    step(20);
    check("t5_low_level", {6'b0, level}, 8'h00);
    pmod[1] = 1'b1;
    step(7);
    reset_n = 1'b0;
    #1;
    check("t5_reset_outputs", {level, rise, fall, toggle}, 8'h00);
    m_level  = 2'b00;
    m_toggle = 2'b00;
    step(3);
    reset_n = 1'b1;
    push_ev(cyc + LAT, 2'b10, 2'b00);
    step(20);
    check("t5_level", {6'b0, level}, 8'h02);
    check("t5_toggle", {6'b0, toggle}, 8'h02);

    // 6: reset with level high emits no fall, then both channels rise together
    pmod    = 2'b00;
    reset_n = 1'b0;
    m_level  = 2'b00;
    m_toggle = 2'b00;
    step(2);
    check("t6_reset_outputs", {level, rise, fall, toggle}, 8'h00);
    reset_n = 1'b1;
    step(5);
    pmod = 2'b11;
    push_ev(cyc + LAT, 2'b11, 2'b00);
    step(20);
    check("t6_level", {6'b0, level}, 8'h03);
    check("t6_toggle", {6'b0, toggle}, 8'h03);

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1);
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pmod_debounce.md
# pmod_debounce

Input-conditioning stage that sits directly upstream of the LED counter on the iCEstick. It synchronises raw PMOD header inputs (reset and enable switches/buttons) to the 12 MHz clock and debounces each one. Per channel it produces a clean level, single-cycle rise/fall pulses and a press-toggled state, so the counter receives glitch-free reset and enable controls.

## Interface
- `WIDTH`, default 2: number of independent input channels (bit 0 = reset button, bit 1 = enable switch).
- `DEBOUNCE_CYCLES`, default 120000: stable-sample count required to accept a change (10 ms at 12 MHz). Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: per-channel counter width.

- `clk`  in  1  12 MHz system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `pmod`  in  WIDTH  raw asynchronous inputs.
- `level`  out  WIDTH  debounced level per channel.
- `rise`  out  WIDTH  one-cycle pulse when `level` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse when `level` goes 1→0.
- `toggle`  out  WIDTH  flips on every `rise` of its channel.

## Operation
- Synchroniser: two flops per channel (`sync1`, `sync2`), both reset to 0; `s = sync2`.
- Per-channel FSM, four states, plus a CNT_W-bit counter `cnt`:
  - STABLE_LO: `level`=0. If `s`=1, go to WAIT_HI and set `cnt`=0.
  - WAIT_HI: if `s`=0, return to STABLE_LO (glitch rejected; no output change). Else if `cnt`==DEBOUNCE_CYCLES-1, go to STABLE_HI with `level`←1, `rise`←1 and `toggle`←~`toggle`. Otherwise `cnt`←`cnt`+1.
  - STABLE_HI: `level`=1. If `s`=0, go to WAIT_LO and set `cnt`=0.
  - WAIT_LO: mirror of WAIT_HI. On `s`=1, return to STABLE_HI. On terminal count, go to STABLE_LO with `level`←0 and `fall`←1.
- `rise` and `fall` are registered. Each is high for exactly one cycle and defaults to 0 in every other cycle. The two are never high together on one channel.
- Channels are fully independent. Simultaneous events on different channels are processed in the same cycle with no interaction.
- The counter never wraps: it stops being compared once the state leaves WAIT_*, and it is cleared on every WAIT_* entry.
- Reset (`reset_n`=0, any time, including mid-WAIT): all channels go to STABLE_LO. `sync1`, `sync2`, `cnt`, `level`, `rise`, `fall` and `toggle` are all 0. No pulse is emitted on reset entry or exit.
- An input already high when reset is released is accepted as a normal 0→1 change. It produces `rise` after the full latency.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0, `toggle`=0.
- Latency: an input change first captured at edge 1 appears on `level` (and its pulse) after edge DEBOUNCE_CYCLES+3.
  - Edges 1–2: synchroniser.
  - Edge 3: WAIT entry.
  - Edge 3+DEBOUNCE_CYCLES: terminal count.
- Rejected glitch: any excursion of `s` lasting fewer than DEBOUNCE_CYCLES+1 consecutive cycles (counted from WAIT entry) produces no output change.
- Pulse timing: a pulse coincides with the cycle in which `level` first shows its new value.
- Maximum accepted toggle rate: one change per DEBOUNCE_CYCLES+1 cycles.

## Test plan
Run with DEBOUNCE_CYCLES=8.

1. Reset, then hold `pmod`=00 for 50 cycles -> all outputs stay 0; no pulses.
2. Drive `pmod[1]` from 0 to 1 and hold -> `level[1]`=1 and `rise[1]`=1 for exactly one cycle, 11 edges after the change; `toggle[1]`=1; channel 0 is unaffected.
3. On `pmod[0]`, apply pulses high for 3, 5 and 8 cycles, separated by 12-cycle gaps -> no `level`/`rise` change on the 3- and 5-cycle pulses. The 8-cycle pulse is also rejected, because `s` must stay high for 9 cycles.
4. Make two clean presses on `pmod[0]` (high 20, low 20, twice) -> two `rise` and two `fall` pulses; `toggle[0]` goes 0→1→0; each `fall` appears 11 edges after the release.
5. Assert `reset_n`=0 mid-WAIT_HI (`cnt`=4), with `pmod[1]` held high -> outputs are 0 immediately. After release, `rise[1]` fires 11 edges after the first sampling edge, with no early pulse.
6. Change both channels 0→1 on the same edge -> `rise`=11 in the same cycle and `level`=11; `toggle`=11.
